// File: rtl/cpu_pkg.sv
// Shared CPU-side types: instruction address and instruction byte widths,
// plus the tagged entry format held by the prefetch queue.
package cpu_pkg;

  localparam int AW = 5;
  localparam int DW = 8;

  typedef logic [AW-1:0] inst_addr_t;
  typedef logic [DW-1:0] inst_byte_t;

  typedef struct packed {
    inst_byte_t data;
    inst_addr_t pc;
  } fetch_entry_t;

  // Sequential fetch address; wraps at the top of instruction memory.
  function automatic inst_addr_t pc_incr(input inst_addr_t pc);
    return pc + inst_addr_t'(1);
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Tagged instruction queue. A flush empties the queue in the same cycle,
// overriding any push; a same-cycle pop has already been handed to the
// consumer, so the flush simply discards whatever remains.
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_nxt;
  logic          push_ok;
  logic          pop_ok;

  // Guard against popping an empty queue; flush suppresses any write.
  assign pop_ok  = pop & (count != '0);
  assign push_ok = push & ~flush;

  assign head = mem[rd_ptr];

  // Occupancy after this cycle's push/pop, before flush is applied.
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  // Storage is not reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointer and occupancy tracking with flush taking priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch queue. Owns the fetch PC, drives the instruction
// memory address directly from a register, captures one byte per clock
// and hands tagged bytes to the CPU over a valid/ready handshake.
module inst_prefetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  output inst_addr_t im_addr_bus,
  input  inst_byte_t im_data_bus,
  output logic       fetch_valid,
  output inst_byte_t fetch_data,
  output inst_addr_t fetch_pc,
  input  logic       fetch_ready,
  input  logic       redirect,
  input  inst_addr_t redirect_pc
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  inst_addr_t    fpc;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;

  // Memory address comes straight from the PC register so that neither
  // fetch_ready nor redirect can reach the address bus combinationally.
  assign im_addr_bus = fpc;

  assign fetch_valid = (count != '0);
  assign pop         = fetch_valid & fetch_ready;
  // A full queue still accepts a byte when the head leaves this cycle.
  assign push        = ~redirect & ((count < FULL) | pop);

  assign wr_entry.data = im_data_bus;
  assign wr_entry.pc   = fpc;

  assign fetch_data = fetch_valid ? head.data : '0;
  assign fetch_pc   = fetch_valid ? head.pc   : '0;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  // Fetch PC: redirect wins, otherwise advance on every captured byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc <= '0;
    end else if (redirect) begin
      fpc <= redirect_pc;
    end else if (push) begin
      fpc <= pc_incr(fpc);
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: free-run, address wrap, stall,
// redirect with pop, back-to-back redirects and mid-stall async reset.
module tb_inst_prefetch;

  logic       clk;
  logic       rst;
  logic [4:0] im_addr_bus;
  logic [7:0] im_data_bus;
  logic       fetch_valid;
  logic [7:0] fetch_data;
  logic [4:0] fetch_pc;
  logic       fetch_ready;
  logic       redirect;
  logic [4:0] redirect_pc;

  logic [7:0] imem [32];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] last_pop = '0;
  logic       watch10 = 1'b0;
  logic       saw10 = 1'b0;

  inst_prefetch #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .im_addr_bus (im_addr_bus),
    .im_data_bus (im_data_bus),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  assign im_data_bus = imem[im_addr_bus];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record the pc of every completed handshake.
  always @(posedge clk) begin
    if (rst && fetch_valid && fetch_ready) last_pop = fetch_pc;
  end

  // Flag any presentation of pc 10 while the back-to-back window is open.
  always @(negedge clk) begin
    if (watch10 && fetch_valid && fetch_pc == 5'd10) saw10 = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 8'(i + 8'h40);
    rst         = 1'b0;
    fetch_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_addr",  32'(im_addr_bus), 32'h0);
    chk("rst_valid", 32'(fetch_valid), 32'h0);
    chk("rst_data",  32'(fetch_data),  32'h0);
    chk("rst_pc",    32'(fetch_pc),    32'h0);

    // Release: address 0 presented, nothing valid yet
    rst = 1'b1;
    chk("rel_addr",  32'(im_addr_bus), 32'h0);
    chk("rel_valid", 32'(fetch_valid), 32'h0);
    @(negedge clk);

    // Free-run through the wrap point: 0..31, 0, 1
    for (int k = 0; k < 34; k++) begin
      chk("run_valid", 32'(fetch_valid), 32'h1);
      chk("run_pc",    32'(fetch_pc),    32'(k % 32));
      chk("run_data",  32'(fetch_data),  32'((k % 32) + 8'h40));
      @(negedge clk);
    end

    // Stall from head pc 3
    @(negedge clk);
    chk("stall_start_pc", 32'(fetch_pc), 32'd3);
    fetch_ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("stall_valid", 32'(fetch_valid), 32'h1);
    chk("stall_pc",    32'(fetch_pc),    32'd3);
    chk("stall_addr",  32'(im_addr_bus), 32'd7);
    fetch_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("drain_pc",   32'(fetch_pc),   32'(3 + j));
      chk("drain_data", 32'(fetch_data), 32'(3 + j + 8'h40));
      @(negedge clk);
    end
    chk("drain_next_pc", 32'(fetch_pc), 32'd8);

    // Move the head to pc 5 via a redirect
    redirect    = 1'b1;
    redirect_pc = 5'd5;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    chk("pre_valid", 32'(fetch_valid), 32'h1);
    chk("pre_pc",    32'(fetch_pc),    32'd5);

    // Redirect to 20 with a simultaneous pop of pc 5
    redirect    = 1'b1;
    redirect_pc = 5'd20;
    @(negedge clk);
    redirect = 1'b0;
    chk("rd_popped", 32'(last_pop),    32'd5);
    chk("rd_valid0", 32'(fetch_valid), 32'h0);
    chk("rd_data0",  32'(fetch_data),  32'h0);
    chk("rd_addr",   32'(im_addr_bus), 32'd20);
    @(negedge clk);
    chk("rd_valid1", 32'(fetch_valid), 32'h1);
    chk("rd_pc",     32'(fetch_pc),    32'd20);
    chk("rd_data",   32'(fetch_data),  32'h54);

    // Back-to-back redirects: 10 then 25
    watch10     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 5'd10;
    @(negedge clk);
    chk("b2b_valid_mid", 32'(fetch_valid), 32'h0);
    redirect_pc = 5'd25;
    @(negedge clk);
    redirect = 1'b0;
    chk("b2b_valid0", 32'(fetch_valid), 32'h0);
    chk("b2b_addr",   32'(im_addr_bus), 32'd25);
    @(negedge clk);
    chk("b2b_valid1", 32'(fetch_valid), 32'h1);
    chk("b2b_pc",     32'(fetch_pc),    32'd25);
    chk("b2b_data",   32'(fetch_data),  32'h59);

    // Build count=3 under stall, then assert reset between edges
    fetch_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_pc",   32'(fetch_pc),    32'd25);
    chk("mid_addr", 32'(im_addr_bus), 32'd28);
    chk("no_pc10",  32'(saw10),       32'h0);
    watch10 = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(fetch_valid), 32'h0);
    chk("arst_data",  32'(fetch_data),  32'h0);
    chk("arst_pc",    32'(fetch_pc),    32'h0);
    chk("arst_addr",  32'(im_addr_bus), 32'h0);

    // Restart after reset
    @(negedge clk);
    rst         = 1'b1;
    fetch_ready = 1'b1;
    chk("rs_valid0", 32'(fetch_valid), 32'h0);
    @(negedge clk);
    chk("rs_valid1", 32'(fetch_valid), 32'h1);
    chk("rs_pc",     32'(fetch_pc),    32'h0);
    chk("rs_data",   32'(fetch_data),  32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
